// File: rtl/i2c_spi_pkg.sv
// Shared definitions for the I2C-bridge / local SPI transfer scheduler:
// SPI master register map, CTRL/STATUS bit positions and the scheduler FSM states.
package i2c_spi_pkg;

  // SPI master register addresses
  localparam logic [1:0] ADDR_TXDATA = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RXDATA = 2'd3;

  // CTRL register fields
  localparam int CTRL_GO_BIT = 0;
  localparam int CTRL_SS_LSB = 1;
  localparam int CTRL_SS_MSB = 2;

  // STATUS register fields
  localparam int STATUS_BUSY_BIT = 0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_TX   = 3'd1,
    WR_CTRL = 3'd2,
    POLL    = 3'd3,
    RD_RX   = 3'd4,
    DONE    = 3'd5
  } xfer_state_e;

  // CTRL value that starts a transfer on the given slave select
  function automatic logic [7:0] ctrl_word(input logic [1:0] ss);
    logic [7:0] w;
    w = 8'h00;
    w[CTRL_SS_MSB:CTRL_SS_LSB] = ss;
    w[CTRL_GO_BIT] = 1'b1;
    return w;
  endfunction

  // Requester index to its ack_o bit
  function automatic logic [1:0] owner_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/i2c_spi_rr_arb.sv
// Two-way round-robin arbiter. A sole requester always wins; on a tie the
// requester that was not granted last time wins. After reset requester 0
// holds the tie-break.
module i2c_spi_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       grant_valid,
  output logic       grant_idx
);

  logic prio_q;  // requester index that wins a tie

  // Grant decision from current requests and the tie-break pointer
  always_comb begin
    grant_valid = |req;
    if (req == 2'b11) begin
      grant_idx = prio_q;
    end else begin
      grant_idx = req[1];
    end
  end

  // Hand the tie-break to the other requester whenever a grant is consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else if (take && grant_valid) begin
      prio_q <= ~grant_idx;
    end
  end

endmodule

// File: rtl/i2c_spi_xfer_sched.sv
// Schedules single-byte SPI transfers for two requesters (I2C bridge and local)
// onto a Wishbone classic SPI master: write TXDATA, write CTRL with go, poll
// STATUS until not busy (bounded by POLL_LIMIT), read RXDATA, then ack the owner.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | bus idle, arbitrate pending requests
// WR_TX   | write latched TX byte to TXDATA
// WR_CTRL | write {ss, go} to CTRL to launch the SPI shift
// POLL    | read STATUS until busy clears or the poll limit is reached
// RD_RX   | read received byte from RXDATA
// DONE    | one-cycle ack_o (and err_o on timeout) to the owner
module i2c_spi_xfer_sched
  import i2c_spi_pkg::*;
#(
  parameter int POLL_LIMIT = 255
) (
  input  logic        i2c_wb_clk_i,
  input  logic        i2c_wb_rst_i,
  input  logic [1:0]  req_i,
  input  logic [15:0] req_tx_i,
  input  logic [3:0]  req_ss_i,
  output logic [1:0]  ack_o,
  output logic        err_o,
  output logic [7:0]  rx_data_o,
  output logic        busy_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [1:0]  wbm_adr_o,
  output logic [7:0]  wbm_dat_o,
  input  logic [7:0]  wbm_dat_i,
  input  logic        wbm_ack_i
);

  // Poll counter value seen on the last permitted STATUS read
  localparam logic [7:0] POLL_LAST = 8'(POLL_LIMIT - 1);

  xfer_state_e state_q;
  logic        owner_q;
  logic [1:0]  ss_q;
  logic [7:0]  poll_cnt_q;

  logic        grant_valid;
  logic        grant_idx;
  logic        arb_take;

  assign arb_take = (state_q == IDLE);

  i2c_spi_rr_arb u_arb (
    .clk         (i2c_wb_clk_i),
    .rst         (i2c_wb_rst_i),
    .req         (req_i),
    .take        (arb_take),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Transfer sequencer; all bus and status outputs are registered here
  always_ff @(posedge i2c_wb_clk_i) begin
    if (i2c_wb_rst_i) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      ss_q       <= 2'b00;
      poll_cnt_q <= 8'd0;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
      wbm_we_o   <= 1'b0;
      wbm_adr_o  <= ADDR_TXDATA;
      wbm_dat_o  <= 8'h00;
      ack_o      <= 2'b00;
      err_o      <= 1'b0;
      rx_data_o  <= 8'h00;
      busy_o     <= 1'b0;
    end else begin
      ack_o <= 2'b00;
      err_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            state_q    <= WR_TX;
            owner_q    <= grant_idx;
            ss_q       <= grant_idx ? req_ss_i[3:2] : req_ss_i[1:0];
            poll_cnt_q <= 8'd0;
            wbm_cyc_o  <= 1'b1;
            wbm_stb_o  <= 1'b1;
            wbm_we_o   <= 1'b1;
            wbm_adr_o  <= ADDR_TXDATA;
            wbm_dat_o  <= grant_idx ? req_tx_i[15:8] : req_tx_i[7:0];
            busy_o     <= 1'b1;
          end
        end

        WR_TX: begin
          if (wbm_ack_i) begin
            state_q   <= WR_CTRL;
            wbm_adr_o <= ADDR_CTRL;
            wbm_dat_o <= ctrl_word(ss_q);
          end
        end

        WR_CTRL: begin
          if (wbm_ack_i) begin
            state_q   <= POLL;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= ADDR_STATUS;
            wbm_dat_o <= 8'h00;
          end
        end

        POLL: begin
          if (wbm_ack_i) begin
            if (!wbm_dat_i[STATUS_BUSY_BIT]) begin
              state_q   <= RD_RX;
              wbm_adr_o <= ADDR_RXDATA;
            end else begin
              poll_cnt_q <= poll_cnt_q + 8'd1;
              // Still busy on the last allowed read: give up without RXDATA
              if (poll_cnt_q == POLL_LAST) begin
                state_q   <= DONE;
                wbm_cyc_o <= 1'b0;
                wbm_stb_o <= 1'b0;
                wbm_adr_o <= ADDR_TXDATA;
                ack_o     <= owner_onehot(owner_q);
                err_o     <= 1'b1;
                rx_data_o <= 8'h00;
              end
            end
          end
        end

        RD_RX: begin
          if (wbm_ack_i) begin
            state_q   <= DONE;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_adr_o <= ADDR_TXDATA;
            ack_o     <= owner_onehot(owner_q);
            rx_data_o <= wbm_dat_i;
          end
        end

        DONE: begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
        end

        default: begin
          state_q   <= IDLE;
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
          wbm_we_o  <= 1'b0;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_spi_xfer_sched.sv
// Directed bench for i2c_spi_xfer_sched: a behavioural Wishbone SPI-master
// slave with configurable wait states and STATUS-busy count, plus a second
// instance with POLL_LIMIT=3 against an always-busy slave for the timeout case.
module tb_i2c_spi_xfer_sched;
  import i2c_spi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req;
  logic [15:0] req_tx;
  logic [3:0]  req_ss;
  logic [1:0]  ack;
  logic        err;
  logic [7:0]  rx;
  logic        busy;
  logic        cyc, stb, we;
  logic [1:0]  adr;
  logic [7:0]  dat_o, dat_i;
  logic        ack_m = 1'b0;

  // Slave knobs and log
  int          busy_reads = 0;
  int          wait_cyc   = 0;
  logic [7:0]  rx_val     = 8'h00;
  int          wcnt = 0, poll_seen = 0;
  int          n_tx = 0, n_ctrl = 0, n_status = 0, n_rx = 0, unstable = 0;
  logic [7:0]  last_tx = 8'h00, last_ctrl = 8'h00;
  logic        held_valid = 1'b0;
  logic [1:0]  held_adr = 2'b00;
  logic [7:0]  held_dat = 8'h00;
  logic        held_we  = 1'b0;

  // Timeout instance
  logic [1:0]  req_to;
  logic [1:0]  ack_to;
  logic        err_to, busy_to;
  logic [7:0]  rx_to;
  logic        cyc2, stb2, we2;
  logic [1:0]  adr2;
  logic [7:0]  dat2_o, dat2_i;
  logic        ack2 = 1'b0;
  logic        to_busy = 1'b0;
  int          n2_status = 0, n2_rx = 0;

  int checks = 0;
  int errs   = 0;

  i2c_spi_xfer_sched #(.POLL_LIMIT(8)) dut (
    .i2c_wb_clk_i (clk),
    .i2c_wb_rst_i (rst),
    .req_i        (req),
    .req_tx_i     (req_tx),
    .req_ss_i     (req_ss),
    .ack_o        (ack),
    .err_o        (err),
    .rx_data_o    (rx),
    .busy_o       (busy),
    .wbm_cyc_o    (cyc),
    .wbm_stb_o    (stb),
    .wbm_we_o     (we),
    .wbm_adr_o    (adr),
    .wbm_dat_o    (dat_o),
    .wbm_dat_i    (dat_i),
    .wbm_ack_i    (ack_m)
  );

  i2c_spi_xfer_sched #(.POLL_LIMIT(3)) dut_to (
    .i2c_wb_clk_i (clk),
    .i2c_wb_rst_i (rst),
    .req_i        (req_to),
    .req_tx_i     (16'h1111),
    .req_ss_i     (4'b0000),
    .ack_o        (ack_to),
    .err_o        (err_to),
    .rx_data_o    (rx_to),
    .busy_o       (busy_to),
    .wbm_cyc_o    (cyc2),
    .wbm_stb_o    (stb2),
    .wbm_we_o     (we2),
    .wbm_adr_o    (adr2),
    .wbm_dat_o    (dat2_o),
    .wbm_dat_i    (dat2_i),
    .wbm_ack_i    (ack2)
  );

  // Main slave read data
  always_comb begin
    dat_i = 8'hEE;
    if (adr == ADDR_STATUS) dat_i = {7'b0, (poll_seen < busy_reads)};
    else if (adr == ADDR_RXDATA) dat_i = rx_val;
  end

  // Main slave: ack after wait_cyc extra cycles, log accesses, check stability
  always @(posedge clk) begin
    if (stb && !ack_m) begin
      if (wcnt >= wait_cyc) begin
        ack_m <= 1'b1;
        wcnt  <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      ack_m <= 1'b0;
      wcnt  <= 0;
    end
    if (stb && ack_m) begin
      if (we && adr == ADDR_TXDATA) begin
        n_tx <= n_tx + 1; last_tx <= dat_o; poll_seen <= 0;
      end
      if (we && adr == ADDR_CTRL) begin
        n_ctrl <= n_ctrl + 1; last_ctrl <= dat_o;
      end
      if (!we && adr == ADDR_STATUS) begin
        n_status <= n_status + 1; poll_seen <= poll_seen + 1;
      end
      if (!we && adr == ADDR_RXDATA) n_rx <= n_rx + 1;
    end
    if (stb && held_valid && (adr != held_adr || dat_o != held_dat || we != held_we))
      unstable <= unstable + 1;
    held_valid <= stb && !ack_m;
    held_adr   <= adr;
    held_dat   <= dat_o;
    held_we    <= we;
  end

  assign dat2_i = (adr2 == ADDR_STATUS) ? {7'b0, to_busy} : 8'h77;

  // Timeout-instance slave: zero wait states
  always @(posedge clk) begin
    ack2 <= stb2 && !ack2;
    if (stb2 && ack2) begin
      if (!we2 && adr2 == ADDR_STATUS) n2_status <= n2_status + 1;
      if (!we2 && adr2 == ADDR_RXDATA) n2_rx <= n2_rx + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait for an ack on the main (which=0) or timeout (which=1) instance;
  // cycles is the edge count at which it appeared, 0 if the budget expired
  task automatic wait_ack(input bit which, input int budget, output int cycles);
    cycles = 0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      if ((which ? ack_to : ack) != 2'b00) begin
        cycles = k;
        break;
      end
    end
  endtask

  initial begin
    int lat, s_tx, s_st, s_rx, s_un, s2_st, s2_rx;
    logic [1:0] exp_ack, seen;
    bit in_poll;

    rst = 1'b1; req = 2'b00; req_tx = 16'h0000; req_ss = 4'h0; req_to = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", cyc, 0);
    chk("rst_stb", stb, 0);
    chk("rst_we", we, 0);
    chk("rst_adr", adr, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_rx", rx, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // Single transfer, latency and bus contents
    req_tx = 16'h00A5; req_ss = 4'b0010; rx_val = 8'h3C; busy_reads = 0;
    s_tx = n_tx; s_st = n_status; s_rx = n_rx;
    req = 2'b01;
    wait_ack(0, 30, lat);
    req = 2'b00;
    chk("t1_latency", lat, 9);
    chk("t1_ack", ack, 2'b01);
    chk("t1_err", err, 0);
    chk("t1_rx", rx, 8'h3C);
    chk("t1_busy_done", busy, 1);
    chk("t1_tx_wr", last_tx, 8'hA5);
    chk("t1_ctrl_wr", last_ctrl, 8'h05);
    chk("t1_n_tx", n_tx - s_tx, 1);
    chk("t1_n_status", n_status - s_st, 1);
    chk("t1_n_rx", n_rx - s_rx, 1);
    @(posedge clk); #1;
    chk("t1_ack_pulse", ack, 0);
    chk("t1_busy_idle", busy, 0);
    chk("t1_rx_hold", rx, 8'h3C);
    chk("t1_cyc_idle", cyc, 0);

    // Contention from reset: grants alternate 0,1,0,1
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    req_tx = 16'h9966; req_ss = 4'b1100;
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_ack = (i % 2 == 0) ? 2'b01 : 2'b10;
      wait_ack(0, 40, lat);
      if (i == 3) req = 2'b00;
      chk("cont_ack", ack, exp_ack);
      chk("cont_tx", last_tx, (i % 2 == 0) ? 8'h66 : 8'h99);
      chk("cont_ctrl", last_ctrl, (i % 2 == 0) ? 8'h01 : 8'h07);
    end
    repeat (2) @(posedge clk);

    // Slow slave: 4 busy reads then idle; requester drops req mid-transfer
    busy_reads = 4; rx_val = 8'h81; req_tx = 16'h0012; req_ss = 4'b0001;
    s_st = n_status; s_rx = n_rx;
    req = 2'b01;
    repeat (3) @(posedge clk);
    #1 req = 2'b00;
    wait_ack(0, 60, lat);
    chk("slow_ack", ack, 2'b01);
    chk("slow_err", err, 0);
    chk("slow_rx", rx, 8'h81);
    chk("slow_n_status", n_status - s_st, 5);
    chk("slow_n_rx", n_rx - s_rx, 1);
    repeat (2) @(posedge clk);

    // Timeout instance: normal transfer first so rx_data_o is non-zero
    to_busy = 1'b0;
    req_to = 2'b01;
    wait_ack(1, 30, lat);
    req_to = 2'b00;
    chk("to_pre_ack", ack_to, 2'b01);
    chk("to_pre_rx", rx_to, 8'h77);
    chk("to_pre_err", err_to, 0);
    repeat (2) @(posedge clk);
    to_busy = 1'b1;
    s2_st = n2_status; s2_rx = n2_rx;
    req_to = 2'b01;
    wait_ack(1, 40, lat);
    req_to = 2'b00;
    chk("to_ack", ack_to, 2'b01);
    chk("to_err", err_to, 1);
    chk("to_rx", rx_to, 8'h00);
    chk("to_n_status", n2_status - s2_st, 3);
    chk("to_n_rx", n2_rx - s2_rx, 0);
    @(posedge clk); #1;
    chk("to_err_pulse", err_to, 0);
    chk("to_busy_idle", busy_to, 0);

    // Reset while in POLL, then requester 1 served
    busy_reads = 1000; req_tx = 16'h4400; req_ss = 4'b0000;
    req = 2'b01;
    in_poll = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (stb && adr == ADDR_STATUS) begin
        in_poll = 1'b1;
        break;
      end
    end
    chk("rp_reached_poll", in_poll, 1);
    req = 2'b00;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rp_cyc", cyc, 0);
    chk("rp_stb", stb, 0);
    chk("rp_busy", busy, 0);
    chk("rp_ack", ack, 0);
    seen = 2'b00;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      seen = seen | ack;
    end
    chk("rp_no_ack", seen, 0);
    busy_reads = 0;
    req = 2'b10;
    wait_ack(0, 30, lat);
    req = 2'b00;
    chk("rp_req1_ack", ack, 2'b10);
    chk("rp_req1_tx", last_tx, 8'h44);
    repeat (2) @(posedge clk);

    // Wait states: slave acks 3 cycles late on every access
    wait_cyc = 3; rx_val = 8'hC3; req_tx = 16'h5A00; req_ss = 4'b0100;
    s_un = unstable;
    req = 2'b10;
    wait_ack(0, 100, lat);
    req = 2'b00;
    chk("ws_ack", ack, 2'b10);
    chk("ws_rx", rx, 8'hC3);
    chk("ws_tx_wr", last_tx, 8'h5A);
    chk("ws_ctrl_wr", last_ctrl, 8'h03);
    chk("ws_stable", unstable - s_un, 0);
    @(posedge clk); #1;
    chk("ws_rx_hold", rx, 8'hC3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/i2c_spi_xfer_sched.md
I2C_SPI_XFER_SCHED -- requirements
Module: i2c_spi_xfer_sched

Interface
REQ-001 SHALL have parameter POLL_LIMIT, default 255, giving the maximum number of STATUS reads per transfer before abort.
REQ-002 SHALL have port i2c_wb_clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i2c_wb_rst_i, input, 1 bit: the reset, synchronous and active-high.
REQ-004 SHALL have port req_i, input, 2 bits: per-requester transfer request, level; requester 0 is the I2C bridge, requester 1 is local.
REQ-005 SHALL have port req_tx_i, input, 16 bits: TX byte per requester; [7:0] is requester 0, [15:8] is requester 1.
REQ-006 SHALL have port req_ss_i, input, 4 bits: 2-bit slave select per requester, packed the same way as req_tx_i.
REQ-007 SHALL have port ack_o, output, 2 bits: one-cycle completion pulse to the owning requester.
REQ-008 SHALL have port err_o, output, 1 bit: pulses together with ack_o when a transfer was aborted by poll timeout.
REQ-009 SHALL have port rx_data_o, output, 8 bits: received byte, valid in the ack_o cycle.
REQ-010 SHALL have port busy_o, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-011 SHALL have the Wishbone classic master ports to the SPI master:
- wbm_cyc_o, output, 1 bit
- wbm_stb_o, output, 1 bit
- wbm_we_o, output, 1 bit
- wbm_adr_o, output, 2 bits
- wbm_dat_o, output, 8 bits
- wbm_dat_i, input, 8 bits
- wbm_ack_i, input, 1 bit

Function
REQ-012 SHALL use this SPI master register map:
- address 0: TXDATA
- address 1: CTRL, bit0 = go, bits2:1 = ss
- address 2: STATUS, bit0 = busy
- address 3: RXDATA
REQ-013 SHALL implement the FSM states IDLE, WR_TX, WR_CTRL, POLL, RD_RX and DONE.
REQ-014 In IDLE with any req_i bit high, SHALL grant one requester, latch its TX byte, ss and identity, and enter WR_TX on the next cycle.
REQ-015 Arbitration SHALL be round-robin:
- a sole requester wins;
- if both request, the requester not granted last time wins;
- after reset, requester 0 has priority.
REQ-016 wbm_cyc_o and wbm_stb_o SHALL be high throughout WR_TX, WR_CTRL, POLL and RD_RX, and low in IDLE and DONE.
REQ-017 Each bus state SHALL hold its address and data until wbm_ack_i is sampled high, then advance on that edge.
REQ-018 Per-state bus access:
- WR_TX SHALL write the latched TX byte to address 0 (wbm_we_o=1).
- WR_CTRL SHALL write {5'b0, ss, 1'b1} to address 1 (wbm_we_o=1).
- POLL SHALL read address 2 (wbm_we_o=0).
- RD_RX SHALL read address 3 (wbm_we_o=0).
REQ-019 On a POLL ack: if wbm_dat_i[0]=0, SHALL go to RD_RX; otherwise SHALL increment an 8-bit poll counter and remain in POLL.
REQ-020 When the POLL_LIMIT-th consecutive STATUS read returns busy, SHALL go to DONE with err flagged and rx_data_o=0, skipping RD_RX.
REQ-021 On the RD_RX ack, SHALL capture wbm_dat_i into rx_data_o.
REQ-022 DONE SHALL last exactly one cycle, pulse ack_o of the owner and err_o if flagged, then return to IDLE.
REQ-023 A requester dropping req_i mid-transfer SHALL NOT abort the transfer; ack_o still pulses.
REQ-024 Requests arriving during a transfer SHALL wait; a requester still holding req_i in IDLE is re-arbitrated.
REQ-025 rx_data_o SHALL hold its last value outside the ack_o cycle.
REQ-026 With a slave acking one cycle after stb rises and STATUS not busy on the first read, ack_o SHALL pulse 9 cycles after the IDLE cycle that sampled req_i.

Reset
REQ-027 When i2c_wb_rst_i is high at a clock edge, SHALL go to IDLE with these values on the next cycle:
- cyc/stb/we = 0
- adr = 0, dat_o = 0
- ack_o = 0, err_o = 0, rx_data_o = 0, busy_o = 0
- poll counter = 0
- round-robin pointer favouring requester 0
REQ-028 Reset asserted mid-transfer SHALL abandon the bus cycle without issuing ack_o.

Structure
REQ-029 Shared package i2c_spi_pkg SHALL hold:
- the register address constants TXDATA/CTRL/STATUS/RXDATA;
- the CTRL and STATUS bit positions;
- the FSM state enum.
REQ-030 The 2-way round-robin grant logic SHALL be one sub-module, i2c_spi_rr_arb.

Verification
REQ-031 Single transfer: req_i=01, TX=0xA5, ss=2, slave returns busy=0 and RXDATA=0x3C -> writes 0xA5@0 and 0x05@1, ack_o=01 at cycle 9, rx_data_o=0x3C, err_o=0.
REQ-032 Contention: req_i=11 held -> grants alternate 0,1,0,1; each ack_o is one-hot with no overlap.
REQ-033 Slow slave: STATUS busy for 4 reads, then idle -> exactly 5 STATUS reads, then an RXDATA read, then ack_o.
REQ-034 Timeout: STATUS always busy, POLL_LIMIT=3 -> 3 STATUS reads, ack_o and err_o pulse together, rx_data_o=0, no RXDATA read.
REQ-035 Reset in POLL -> next cycle cyc/stb=0 and busy_o=0, no ack_o; a following req_i=10 is served by requester 1.
REQ-036 Wait states: wbm_ack_i delayed 3 cycles per access -> adr, dat_o and we stable until ack; final rx_data_o is correct.
